// File: rtl/usb_utmi_pkg.sv
// usb_utmi_pkg: shared UTMI types and constants for the FS transmit path.
// The USB_UTMI_TX_OPMODE_EN build option is consumed by usb_utmi_tx.
package usb_utmi_pkg;

    typedef enum logic [1:0] {
        OpNormal        = 2'b00,
        OpNonDriving    = 2'b01,
        OpDisableBsNrzi = 2'b10,
        OpReserved      = 2'b11
    } utmi_op_mode_t;

    // Encoded as {dp, dn}.
    typedef enum logic [1:0] {
        LineSe0 = 2'b00,
        LineK   = 2'b01,
        LineJ   = 2'b10
    } usb_line_state_t;

    localparam logic [7:0]  USB_SYNC_BYTE    = 8'h80;
    localparam int unsigned USB_BITSTUFF_LEN = 6;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StData,
        StEop
    } tx_state_t;

endpackage

// File: rtl/usb_utmi_if.sv
// usb_utmi_if: UTMI transmit handshake between the SIE (master) and the macrocell (slave).
interface usb_utmi_if;
    import usb_utmi_pkg::*;

    utmi_op_mode_t op_mode;
    logic [7:0]    data_in;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_active;

    modport master (
        output op_mode,
        output data_in,
        output tx_valid,
        input  tx_ready,
        input  tx_active
    );

    modport slave (
        input  op_mode,
        input  data_in,
        input  tx_valid,
        output tx_ready,
        output tx_active
    );

endinterface

// File: rtl/usb_utmi_tx_bitenc.sv
// usb_utmi_tx_bitenc: per-bit bit stuffing and NRZI line level (1 = J).
// stall_o flags that the next strobe sends a stuff bit instead of bit_i.
module usb_utmi_tx_bitenc
    import usb_utmi_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic strobe_i,
    input  logic bit_i,
    input  logic raw_i,
    input  logic stuff_en_i,
    input  logic clear_i,
    output logic level_o,
    output logic stall_o
);

    logic       level_q, level_d;
    logic [2:0] ones_q, ones_d;

    assign stall_o = stuff_en_i && (ones_q == 3'(USB_BITSTUFF_LEN));
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        ones_d  = ones_q;
        if (clear_i) begin
            level_d = 1'b1;
            ones_d  = '0;
        end else if (strobe_i) begin
            if (stall_o) begin
                level_d = ~level_q;
                ones_d  = '0;
            end else if (raw_i) begin
                level_d = bit_i;
                ones_d  = '0;
            end else if (bit_i) begin
                ones_d  = ones_q + 3'd1;
            end else begin
                level_d = ~level_q;
                ones_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b1;
            ones_q  <= '0;
        end else begin
            level_q <= level_d;
            ones_q  <= ones_d;
        end
    end

endmodule

// File: rtl/usb_utmi_tx.sv
// usb_utmi_tx: UTMI FS transmit path (SYNC, stuffed NRZI data, EOP) onto D+/D-.
// Define USB_UTMI_TX_OPMODE_EN to honour op_mode DISABLE_BS_NRZI (raw data bits).
module usb_utmi_tx
    import usb_utmi_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 4
) (
    input  logic      clk,
    input  logic      rst,
    usb_utmi_if.slave utmi,
    output logic      dp_tx,
    output logic      dn_tx,
    output logic      tx_oe
);

    localparam int unsigned    CntW    = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_PER_BIT - 1);

    tx_state_t       state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            raw_q, raw_d;
    logic            se0_q, se0_d;
    logic            active_q, active_d;

    logic            bit_end;
    logic            raw_req;
    logic            ready;
    logic            enc_strobe, enc_bit, enc_raw, enc_clear;
    logic            enc_level, enc_stall;
    usb_line_state_t line;

`ifdef USB_UTMI_TX_OPMODE_EN
    assign raw_req = (utmi.op_mode == OpDisableBsNrzi);
`else
    assign raw_req = 1'b0;
`endif

    assign bit_end = (bit_cnt_q == CntLast);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        raw_d      = raw_q;
        se0_d      = se0_q;
        active_d   = active_q;
        enc_strobe = 1'b0;
        enc_bit    = 1'b0;
        enc_raw    = 1'b0;
        enc_clear  = 1'b0;
        ready      = 1'b0;

        if (state_q != StIdle) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + CntW'(1);
        end

        // Each strobe registers the level of the bit that starts on the next cycle.
        unique case (state_q)
            StIdle: begin
                if (utmi.tx_valid && (utmi.op_mode != OpNonDriving)) begin
                    state_d    = StSync;
                    bit_cnt_d  = '0;
                    bit_idx_d  = '0;
                    raw_d      = raw_req;
                    active_d   = 1'b1;
                    enc_strobe = 1'b1;
                    enc_bit    = USB_SYNC_BYTE[0];
                end
            end
            StSync, StData: begin
                if (bit_end) begin
                    if ((state_q == StData) && enc_stall) begin
                        enc_strobe = 1'b1;
                    end else if (bit_idx_q != 3'd7) begin
                        bit_idx_d  = bit_idx_q + 3'd1;
                        enc_strobe = 1'b1;
                        if (state_q == StSync) begin
                            enc_bit = USB_SYNC_BYTE[bit_idx_d];
                        end else begin
                            enc_bit = shift_q[bit_idx_d];
                            enc_raw = raw_q;
                        end
                    end else if (utmi.tx_valid) begin
                        ready      = 1'b1;
                        shift_d    = utmi.data_in;
                        state_d    = StData;
                        bit_idx_d  = '0;
                        enc_strobe = 1'b1;
                        enc_bit    = utmi.data_in[0];
                        enc_raw    = raw_q;
                    end else begin
                        state_d   = StEop;
                        bit_idx_d = '0;
                        se0_d     = 1'b1;
                    end
                end
            end
            StEop: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd0) begin
                        bit_idx_d = 3'd1;
                    end else if (bit_idx_q == 3'd1) begin
                        bit_idx_d = 3'd2;
                        se0_d     = 1'b0;
                        enc_clear = 1'b1;
                    end else begin
                        state_d   = StIdle;
                        bit_idx_d = '0;
                        active_d  = 1'b0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            raw_q     <= 1'b0;
            se0_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            raw_q     <= raw_d;
            se0_q     <= se0_d;
            active_q  <= active_d;
        end
    end

    usb_utmi_tx_bitenc u_bitenc (
        .clk       (clk),
        .rst       (rst),
        .strobe_i  (enc_strobe),
        .bit_i     (enc_bit),
        .raw_i     (enc_raw),
        .stuff_en_i(~raw_q),
        .clear_i   (enc_clear),
        .level_o   (enc_level),
        .stall_o   (enc_stall)
    );

    always_comb begin
        line = LineJ;
        if (se0_q) begin
            line = LineSe0;
        end else if (!enc_level) begin
            line = LineK;
        end
    end

    assign {dp_tx, dn_tx}  = line;
    assign tx_oe           = active_q;
    assign utmi.tx_active  = active_q;
    assign utmi.tx_ready   = ready;

endmodule

// File: tb/tb_usb_utmi_tx.sv
// tb_usb_utmi_tx: directed and random packets checked against a bit-list line model.
module tb_usb_utmi_tx;
    import usb_utmi_pkg::*;

    localparam int CPB = 4;
`ifdef USB_UTMI_TX_OPMODE_EN
    localparam bit RawEn = 1'b1;
`else
    localparam bit RawEn = 1'b0;
`endif
    localparam logic [1:0] LJ = 2'b10;
    localparam logic [1:0] LK = 2'b01;
    localparam logic [1:0] LSe0 = 2'b00;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dp_tx, dn_tx, tx_oe;

    usb_utmi_if utmi ();

    usb_utmi_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk  (clk),
        .rst  (rst),
        .utmi (utmi),
        .dp_tx(dp_tx),
        .dn_tx(dn_tx),
        .tx_oe(tx_oe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] pkt[$];
    logic [1:0] exp_line[$];
    int exp_rdy[$];
    logic [1:0] obs_line[$];
    logic obs_oe[$];
    logic obs_act[$];
    int obs_rdy[$];
    logic m_lvl;
    int m_ones;
    int last_act_len;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", name, obs, exp);
        end
    endtask

    // One line bit per call; a stuff bit follows a sixth consecutive 1.
    task automatic m_bit(input bit b, input bit raw);
        if (raw) begin
            m_lvl = b;
            m_ones = 0;
        end else if (b) begin
            m_ones++;
        end else begin
            m_lvl = ~m_lvl;
            m_ones = 0;
        end
        exp_line.push_back(m_lvl ? LJ : LK);
        if (!raw && m_ones == 6) begin
            m_lvl = ~m_lvl;
            m_ones = 0;
            exp_line.push_back(m_lvl ? LJ : LK);
        end
    endtask

    task automatic build_model(input bit raw);
        logic [7:0] sync_b;
        logic [7:0] b;
        sync_b = 8'h80;
        exp_line.delete();
        exp_rdy.delete();
        m_lvl = 1'b1;
        m_ones = 0;
        for (int i = 0; i < 8; i++) m_bit(sync_b[i], 1'b0);
        foreach (pkt[k]) begin
            exp_rdy.push_back(exp_line.size() * CPB);
            b = pkt[k];
            for (int i = 0; i < 8; i++) m_bit(b[i], raw);
        end
        exp_line.push_back(LSe0);
        exp_line.push_back(LSe0);
        exp_line.push_back(LJ);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called just after a posedge; that next posedge is t0.
    task automatic run_packet(input utmi_op_mode_t mode, input bit raw, input bit chain,
                              input int abort_after, input string tag);
        int len_exp, idx, act_len, oe_bad, last;
        bit done, rdy_now, act_now, run;
        logic [2:0] code;
        build_model(raw);
        len_exp = exp_line.size() * CPB;
        obs_line.delete();
        obs_oe.delete();
        obs_act.delete();
        obs_rdy.delete();
        idx = 0;
        done = 1'b0;
        utmi.op_mode = mode;
        utmi.data_in = (pkt.size() > 0) ? pkt[0] : 8'h00;
        utmi.tx_valid = 1'b1;
        @(negedge clk);
        chk({tag, "_pre_oe"}, {31'd0, tx_oe}, 32'd0);
        @(posedge clk);
        #1;
        if (pkt.size() == 0) utmi.tx_valid = 1'b0;
        for (int c = 1; c <= len_exp + 16; c++) begin
            @(negedge clk);
            obs_line.push_back({dp_tx, dn_tx});
            obs_oe.push_back(tx_oe);
            obs_act.push_back(utmi.tx_active);
            act_now = utmi.tx_active;
            rdy_now = utmi.tx_ready;
            if (rdy_now) obs_rdy.push_back(c);
            @(posedge clk);
            #1;
            if (rdy_now) begin
                idx++;
                if (idx < pkt.size()) begin
                    utmi.data_in = pkt[idx];
                end else begin
                    utmi.tx_valid = 1'b0;
                    utmi.data_in = 8'($urandom);
                end
            end
            if (abort_after != 0 && c == abort_after) return;
            if ((chain && c == len_exp) || !act_now) begin
                done = 1'b1;
                break;
            end
        end
        chk({tag, "_ended"}, {31'd0, done}, 32'd1);
        act_len = 0;
        oe_bad = 0;
        run = 1'b1;
        foreach (obs_act[i]) begin
            if (run && obs_act[i] === 1'b1) act_len++;
            else run = 1'b0;
            if (obs_oe[i] !== obs_act[i]) oe_bad++;
        end
        last_act_len = act_len;
        chk({tag, "_act_len"}, act_len, len_exp);
        chk({tag, "_oe_vs_act"}, oe_bad, 0);
        for (int k = 0; k < exp_line.size(); k++) begin
            code = 3'b100;
            if ((k + 1) * CPB <= obs_line.size()) begin
                code = {1'b0, obs_line[k*CPB]};
                for (int j = 1; j < CPB; j++)
                    if (obs_line[k*CPB+j] !== obs_line[k*CPB]) code[2] = 1'b1;
            end
            chk($sformatf("%s_bit%0d", tag, k), {29'd0, code}, {29'd0, 1'b0, exp_line[k]});
        end
        chk({tag, "_nrdy"}, obs_rdy.size(), exp_rdy.size());
        for (int i = 0; i < exp_rdy.size() && i < obs_rdy.size(); i++)
            chk($sformatf("%s_rdy%0d", tag, i), obs_rdy[i], exp_rdy[i]);
        if (!chain) begin
            last = obs_line.size() - 1;
            chk({tag, "_idle_line"}, {29'd0, obs_line[last], obs_act[last]}, {29'd0, LJ, 1'b0});
        end
    endtask

    initial begin
        int n, nd_bad;
        utmi_op_mode_t mode;
        utmi.op_mode = OpNormal;
        utmi.data_in = 8'h00;
        utmi.tx_valid = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("reset_vals", {27'd0, dp_tx, dn_tx, tx_oe, utmi.tx_ready, utmi.tx_active},
            32'b10000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        pkt = {8'hA5};
        run_packet(OpNormal, 1'b0, 1'b0, 0, "a5");
        chk("a5_act_76", last_act_len, 76);
        chk("a5_rdy_32", (obs_rdy.size() > 0) ? obs_rdy[0] : -1, 32);
        gap(2);

        pkt = {8'hFF, 8'h00};
        run_packet(OpNormal, 1'b0, 1'b0, 0, "ff00");
        chk("ff00_rdy_gap", (obs_rdy.size() > 1) ? obs_rdy[1] - obs_rdy[0] : -1, 36);
        gap(1);

        pkt.delete();
        run_packet(OpNormal, 1'b0, 1'b0, 0, "synconly");
        chk("synconly_act_44", last_act_len, 44);
        gap(3);

        pkt = {8'($urandom), 8'hFF};
        run_packet(OpNormal, 1'b0, 1'b1, 0, "b2b_a");
        pkt = {8'h3C};
        run_packet(OpNormal, 1'b0, 1'b0, 0, "b2b_b");
        gap(2);

        // Abandon mid data bit 3 of 0xFF, with five 1s already counted.
        pkt = {8'hFF};
        run_packet(OpNormal, 1'b0, 1'b0, 11 * CPB + 2, "rstpkt");
        #1 rst = 1'b0;
        #1;
        chk("rst_async", {27'd0, dp_tx, dn_tx, tx_oe, utmi.tx_ready, utmi.tx_active}, 32'b10000);
        utmi.tx_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        pkt = {8'hFF};
        run_packet(OpNormal, 1'b0, 1'b0, 0, "after_rst");
        gap(1);

        nd_bad = 0;
        utmi.op_mode = OpNonDriving;
        utmi.data_in = 8'h5A;
        utmi.tx_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (tx_oe !== 1'b0 || utmi.tx_active !== 1'b0 || utmi.tx_ready !== 1'b0 ||
                {dp_tx, dn_tx} !== LJ) nd_bad++;
        end
        chk("nondriving", nd_bad, 0);
        utmi.tx_valid = 1'b0;
        utmi.op_mode = OpNormal;
        @(posedge clk);
        #1;

        pkt = {8'hFF, 8'hFF};
        run_packet(OpDisableBsNrzi, RawEn, 1'b0, 0, "rawff");
`ifdef USB_UTMI_TX_OPMODE_EN
        chk("rawff_rdy_gap", (obs_rdy.size() > 1) ? obs_rdy[1] - obs_rdy[0] : -1, 32);
`else
        chk("rawff_rdy_gap", (obs_rdy.size() > 1) ? obs_rdy[1] - obs_rdy[0] : -1, 36);
`endif
        gap(1);

        for (int r = 0; r < 8; r++) begin
            pkt.delete();
            n = $urandom_range(0, 4);
            for (int i = 0; i < n; i++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            mode = ($urandom_range(0, 3) == 0) ? OpDisableBsNrzi : OpNormal;
            run_packet(mode, RawEn && (mode == OpDisableBsNrzi), 1'b0, 0,
                       $sformatf("rnd%0d", r));
            gap($urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
